// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Sequential unsigned shift-and-add multiplier feeding the calculator's
// binary-to-BCD display stage. A start pulse in IDLE latches both operands.
// Each CALC cycle conditionally adds the shifted multiplicand and shifts the
// multiplier right. FINISH registers the product and error flag and pulses
// done.
//
// Optional feature: define SHIFT_ADD_EARLY_TERM_EN to leave CALC as soon as
// the remaining multiplier bits are all zero. At least one CALC step always
// runs, and the result is the same as in fixed-latency mode.
//
// Handshake: start is a request that is sampled only in IDLE. There is no
// ready signal; busy=1 means a start will be ignored. done is a one-cycle
// registered pulse, and product/err are valid from that cycle until the next
// FINISH or clr.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        begin a multiplication (IDLE only)
//   clr          clear product/err/show_result (IDLE only, beats start)
//   multiplicand operand A, WIDTH bits
//   multiplier   operand B, WIDTH bits
//   busy         high in CALC and FINISH
//   done         one-cycle completion pulse
//   product      registered 2*WIDTH-bit raw result (never saturated)
//   err          product > LIMIT (too large for four display digits)
//   show_result  1: display product, 0: display operand
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 9999
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 err,
  output logic                 show_result
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // state is kept as a named typed signal so that checkers can bind to it.
  state_t            state;
  state_t            state_nxt;

  logic [WIDTH-1:0]  mcand_r;
  logic [WIDTH-1:0]  mplr_r;
  logic [PW-1:0]     acc;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     addend;
  logic              last_step;

  // The multiplicand is shifted into position by the step count. It is
  // widened first, so the sum can never overflow 2*WIDTH bits.
  always_comb begin
    addend = PW'(mcand_r) << cnt;
  end

  always_comb begin
    last_step = (cnt == CW'(WIDTH - 1));
`ifdef SHIFT_ADD_EARLY_TERM_EN
    // The multiplier value after this step's shift is zero, so no later
    // step can add anything.
    if ((mplr_r >> 1) == '0) begin
      last_step = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !clr) state_nxt = CALC;
      CALC:    if (last_step)     state_nxt = FINISH;
      FINISH:                     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CALC) || (state == FINISH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mcand_r     <= '0;
      mplr_r      <= '0;
      acc         <= '0;
      cnt         <= '0;
      product     <= '0;
      err         <= 1'b0;
      done        <= 1'b0;
      show_result <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            product     <= '0;
            err         <= 1'b0;
            show_result <= 1'b0;
          end else if (start) begin
            mcand_r     <= multiplicand;
            mplr_r      <= multiplier;
            acc         <= '0;
            cnt         <= '0;
            show_result <= 1'b0;
          end
        end
        CALC: begin
          if (mplr_r[0]) begin
            acc <= acc + addend;
          end
          mplr_r <= mplr_r >> 1;
          cnt    <= cnt + CW'(1);
        end
        FINISH: begin
          product     <= acc;
          err         <= (acc > PW'(LIMIT));
          show_result <= 1'b1;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
//
// Directed bench for shift_add_multiplier (WIDTH=8, LIMIT=9999). The bench
// drives inputs 1 ns after a rising edge and samples outputs at the same
// point, so each observation reflects the edge that has just occurred.
// Expected latencies follow SHIFT_ADD_EARLY_TERM_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

  localparam int WIDTH = 8;

  // ---- clock / reset -------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              clr;
  logic [WIDTH-1:0]  multiplicand;
  logic [WIDTH-1:0]  multiplier;
  logic              busy;
  logic              done;
  logic [2*WIDTH-1:0] product;
  logic              err;
  logic              show_result;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(WIDTH), .LIMIT(9999)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clr          (clr),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .err          (err),
    .show_result  (show_result)
  );

  // ---- scoreboard counters -------------------------------------------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected number of edges from the start edge to the done edge.
  function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef SHIFT_ADD_EARLY_TERM_EN
    int len;
    len = 0;
    for (int i = 0; i < WIDTH; i++) if (b[i]) len = i + 1;
    if (len < 1) len = 1;
    return len + 1;
`else
    return WIDTH + 1;
`endif
  endfunction

  // ---- driver tasks --------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen, with a cycle bound. When chk_sr is set,
  // show_result must stay low on every cycle before done.
  task automatic wait_done(input string tag, input bit chk_sr, output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 30) begin
      step();
      lat++;
      if (chk_sr && done !== 1'b1) chk({tag, "_sr_low"}, 32'(show_result), 32'd0);
    end
  endtask

  task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    step();                       // edge 0
    start        = 1'b0;
    // Operand inputs may change freely once the start has been accepted.
    multiplicand = WIDTH'($urandom_range(0, 255));
    multiplier   = WIDTH'($urandom_range(0, 255));
  endtask

  task automatic run_mult(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int exp_p, input int exp_e);
    int lat;
    do_start(a, b);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag, 1'b1, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(b)));
    chk({tag, "_prod"}, 32'(product), 32'(exp_p));
    chk({tag, "_err"}, 32'(err), 32'(exp_e));
    chk({tag, "_sr"}, 32'(show_result), 32'd1);
    step();
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // ---- directed sequence ---------------------------------------------------
  initial begin
    int lat;
    int pulses;
    rst_n = 1'b0; start = 1'b0; clr = 1'b0;
    multiplicand = '0; multiplier = '0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_prod", 32'(product), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sr", 32'(show_result), 32'd0);

    // Basic run and the LIMIT boundary.
    run_mult("m12x13", 8'd12, 8'd13, 156, 0);
    run_mult("m99x101", 8'd99, 8'd101, 9999, 0);
    run_mult("m100x100", 8'd100, 8'd100, 10000, 1);
    run_mult("m255x255", 8'd255, 8'd255, 65025, 1);

    // clr in IDLE wipes the held result.
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_prod", 32'(product), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_sr", 32'(show_result), 32'd0);

    // Start while busy is ignored; operands are not re-latched.
    do_start(8'd0, 8'd200);
    step(); step();
    multiplicand = 8'd255; multiplier = 8'd255; start = 1'b1;
    step();                       // edge 3
    start = 1'b0;
    chk("busy_start_busy", 32'(busy), 32'd1);
    wait_done("busy_start", 1'b1, lat);
    chk("busy_start_lat", 32'(lat + 3), 32'(exp_lat(8'd200)));
    chk("busy_start_prod", 32'(product), 32'd0);
    chk("busy_start_err", 32'(err), 32'd0);

    // Back-to-back start on the done cycle.
    do_start(8'd3, 8'd5);
    chk("b2b_done_clr", 32'(done), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done("b2b", 1'b1, lat);
    chk("b2b_lat", 32'(lat), 32'(exp_lat(8'd5)));
    chk("b2b_prod", 32'(product), 32'd15);
    step();

    // Reset at edge 4 aborts the run with no done pulse.
    do_start(8'd50, 8'd50);
    step(); step(); step();
    rst_n = 1'b0; step(); rst_n = 1'b1;   // edge 4
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_prod", 32'(product), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_sr", 32'(show_result), 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_mult("m7x8", 8'd7, 8'd8, 56, 0);

    // clr during CALC is ignored.
    do_start(8'd10, 8'd10);
    step();
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_calc_busy", 32'(busy), 32'd1);
    wait_done("clr_calc", 1'b1, lat);
    chk("clr_calc_lat", 32'(lat + 2), 32'(exp_lat(8'd10)));
    chk("clr_calc_prod", 32'(product), 32'd100);
    chk("clr_calc_sr", 32'(show_result), 32'd1);
    step();

    // Latency-sensitive vectors (short in early-termination mode).
    run_mult("m3x2", 8'd3, 8'd2, 6, 0);
    run_mult("m9x0", 8'd9, 8'd0, 0, 0);
    run_mult("m1x128", 8'd1, 8'd128, 128, 0);
    run_mult("m0x0", 8'd0, 8'd0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
